// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with registered binary/one-hot grant and bounded hold time.
// Optional owner lock (timeout suppression) is enabled by defining RR_ARB4_LOCK_EN.
module rr_arb4_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
`ifdef RR_ARB4_LOCK_EN
  input  logic             lock,
`endif
  output logic [1:0]       gnt_code,
  output logic [3:0]       gnt,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       gnt_code_reg, gnt_code_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic [1:0] arb_ptr;
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;
  logic [3:0] pick_onehot;
  logic [1:0] pick;
  logic       any_req;
  logic       timeout_en;
  logic       timeout;
  logic       owner_release;

`ifdef RR_ARB4_LOCK_EN
  assign timeout_en = ~lock;
`else
  assign timeout_en = 1'b1;
`endif

  // On a release edge the owner being released becomes the new pointer, so the
  // search must already start after it; in IDLE the stored pointer is current.
  assign arb_ptr = (state_reg == GRANT) ? gnt_code_reg : ptr_reg;
  assign any_req = |req;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      // Candidate gi is the (gi+1)-th index after the pointer; gi=3 is the pointer itself.
      assign cand_idx[gi]    = arb_ptr + 2'(gi + 1);
      assign cand_hit[gi]    = req[cand_idx[gi]];
      assign pick_onehot[gi] = (pick == 2'(gi));
    end
  endgenerate

  always_comb begin
    pick = cand_idx[3];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        pick = cand_idx[i];
      end
    end
  end

  assign timeout       = timeout_en && (hold_cnt_reg == HOLD_LAST);
  assign owner_release = !req[gnt_code_reg] || timeout;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_code_next  = gnt_code_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    hold_cnt_next  = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = GRANT;
          gnt_code_next  = pick;
          gnt_next       = pick_onehot;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end

      GRANT: begin
        if (owner_release) begin
          ptr_next = gnt_code_reg;
          if (any_req) begin
            gnt_code_next  = pick;
            gnt_next       = pick_onehot;
            gnt_valid_next = 1'b1;
            hold_cnt_next  = '0;
          end else begin
            state_next     = IDLE;
            gnt_next       = 4'b0000;
            gnt_valid_next = 1'b0;
            hold_cnt_next  = '0;
          end
        end else if (hold_cnt_reg != HOLD_LAST) begin
          // Saturation only matters while a lock suppresses the timeout.
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        gnt_next       = 4'b0000;
        gnt_valid_next = 1'b0;
        hold_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd3;
      gnt_code_reg  <= 2'd0;
      gnt_reg       <= 4'b0000;
      gnt_valid_reg <= 1'b0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_code_reg  <= gnt_code_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign gnt_code  = gnt_code_reg;
  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign hold_cnt  = hold_cnt_reg;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Directed, table-driven bench for rr_arb4_ctrl (MAX_HOLD=8); lock sequence runs when RR_ARB4_LOCK_EN is defined.
module tb_rr_arb4_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
`ifdef RR_ARB4_LOCK_EN
  logic       lock;
`endif
  logic [1:0] gnt_code;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [7:0] hold_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  rr_arb4_ctrl #(
    .MAX_HOLD(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef RR_ARB4_LOCK_EN
    .lock(lock),
`endif
    .gnt_code(gnt_code),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] code;
    logic       valid;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[15];

  // Apply inputs, let one rising edge pass, then compare 1 time unit later.
  task automatic step_check(input logic r, input logic [3:0] q, input logic [3:0] eg,
                            input logic [1:0] ec, input logic ev, input logic [7:0] ecnt,
                            input string name);
    rst_n = r;
    req   = q;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({gnt, gnt_code, gnt_valid, hold_cnt} === {eg, ec, ev, ecnt}) begin
      pass_cnt++;
      $display("%s: req=%b gnt=%b code=%0d valid=%b cnt=%0d ok", name, q, gnt, gnt_code, gnt_valid, hold_cnt);
    end else begin
      $display("FAIL %s: got gnt=%b code=%0d valid=%b cnt=%0d, expected gnt=%b code=%0d valid=%b cnt=%0d",
               name, gnt, gnt_code, gnt_valid, hold_cnt, eg, ec, ev, ecnt);
    end
  endtask

  task automatic run_vec(input int i);
    step_check(vecs[i].rst_n, vecs[i].req, vecs[i].gnt, vecs[i].code, vecs[i].valid,
               vecs[i].cnt, $sformatf("vec%0d", i));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
`ifdef RR_ARB4_LOCK_EN
    lock  = 1'b0;
`endif

    // rst_n, req, expected gnt, code, valid, hold_cnt
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'd0};  // reset with all requesting
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 8'd0};  // requester 0 first after reset
    vecs[3]  = '{1'b0, 4'b0101, 4'b0000, 2'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'd1};  // req[2] does not pre-empt
    vecs[6]  = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'd0};  // early release, no bubble
    vecs[8]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'd1};
    vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0};  // idle, code held
    vecs[10] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 4'b1100, 4'b1000, 2'd3, 1'b1, 8'd0};  // pointer=2 -> owner 3
    vecs[12] = '{1'b1, 4'b1100, 4'b1000, 2'd3, 1'b1, 8'd1};
    vecs[13] = '{1'b0, 4'b1100, 4'b0000, 2'd0, 1'b0, 8'd0};  // reset mid-grant
    vecs[14] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 8'd0};  // pointer back to 3

    for (int i = 0; i < 3; i++) run_vec(i);

    // Full rotation 0,1,2,3,0 with 8 cycles each; the first cycle of owner 0 was vec2.
    for (int k = 1; k < 40; k++) begin
      automatic logic [1:0] own = 2'((k / 8) % 4);
      automatic logic [3:0] oh  = 4'b0001 << own;
      step_check(1'b1, 4'b1111, oh, own, 1'b1, 8'(k % 8), $sformatf("rot%0d", k));
    end

    for (int i = 3; i < 15; i++) run_vec(i);

    // Single requester: re-granted at timeout, grant never drops.
    step_check(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 8'd0, "single_rst");
    for (int k = 0; k < 20; k++) begin
      step_check(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 8'(k % 8), $sformatf("single%0d", k));
    end

`ifdef RR_ARB4_LOCK_EN
    step_check(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 8'd0, "lock_rst");
    lock = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step_check(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, (k < 7) ? 8'(k) : 8'd7, $sformatf("lock%0d", k));
    end
    lock = 1'b0;
    step_check(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 8'd0, "unlock");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
